// File: rtl/divisor4_seq_ctrl.sv
// Sequential restoring divider: one shared subtract/compare stage, one quotient bit per clock.
// start accepted only in IDLE (ignored while busy); done pulses WIDTH+1 cycles after the accepting edge, 1 for B==0.
module divisor4_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             ERR
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] ext;
  logic [WIDTH+1:0] diff;
  logic             qbit;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             last;

  // rem never exceeds the divisor, so its top bit is always zero and ext equals the
  // WIDTH+1-bit shifted value; the extra bit of diff is the borrow.
  always_comb begin
    ext     = {rem, dvd[WIDTH-1]};
    diff    = ext - {2'b00, dvs};
    qbit    = ~diff[WIDTH+1];
    rem_nxt = qbit ? diff[WIDTH:0] : ext[WIDTH:0];
    quo_nxt = {dvd[WIDTH-2:0], qbit};
    last    = (cnt == CW'(WIDTH - 1));
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Quotient bits enter the dividend register from the LSB as its bits are consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      ERR   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (B != '0) begin
              dvd   <= A;
              dvs   <= B;
              rem   <= '0;
              cnt   <= '0;
              state <= CALC;
            end else begin
              Q     <= '0;
              R     <= '0;
              ERR   <= 1'b1;
              state <= DONE;
            end
          end
        end
        CALC: begin
          dvd <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            Q     <= quo_nxt;
            R     <= rem_nxt[WIDTH-1:0];
            ERR   <= 1'b0;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor4_seq_ctrl.sv
// Bench for divisor4_seq_ctrl: directed ops feed a scoreboard queue; a negedge monitor
// pops one expected result (values and arrival cycle) on every done pulse.
module tb_divisor4_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [3:0] Q;
  logic [3:0] R;
  logic       ERR;

  divisor4_seq_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .ERR   (ERR)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       err;
    int         c;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("Q", Q, e.q);
        check("R", R, e.r);
        check("ERR", ERR, e.err);
        check("done_cycle", cyc, e.c);
        check("busy_with_done", busy, 1);
      end
    end
  end

  // Drive one start pulse from a negedge; returns at the negedge after the accepting edge.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input bit expect_done);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    if (expect_done) begin
      e.q   = (b == 0) ? 4'd0 : a / b;
      e.r   = (b == 0) ? 4'd0 : a % b;
      e.err = (b == 0);
      e.c   = cyc + ((b == 0) ? 1 : 5);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n < 40), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int last_idle;
    int n;
    logic [3:0] prev_b;
    bit first;

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_Q", Q, 0);
    check("rst_R", R, 0);
    check("rst_ERR", ERR, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 13 / 3
    do_op(4'd13, 4'd3, 1);
    check("busy_after_start", busy, 1);
    wait_drain();
    repeat (3) @(negedge clk);
    check("hold_Q_13_3", Q, 4);
    check("hold_R_13_3", R, 1);

    // 15 / 1, then 5 / 7; old result must stay visible during the new CALC
    do_op(4'd15, 4'd1, 1);
    check("Q_kept_during_calc", Q, 4);
    wait_drain();
    do_op(4'd5, 4'd7, 1);
    wait_drain();
    repeat (2) @(negedge clk);
    check("hold_Q_5_7", Q, 0);
    check("hold_R_5_7", R, 5);

    // Divide by zero, then a normal op clears ERR
    do_op(4'd9, 4'd0, 1);
    wait_drain();
    check("err_after_div0", ERR, 1);
    do_op(4'd8, 4'd2, 1);
    wait_drain();
    check("err_cleared", ERR, 0);
    check("Q_8_2", Q, 4);

    // start and new operands during CALC are ignored
    do_op(4'd14, 4'd4, 1);
    @(negedge clk);
    A = 4'd2;
    B = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    check("ignored_Q", Q, 3);
    check("ignored_R", R, 2);
    check("ignored_no_extra_op", busy, 0);

    // Reset in the second CALC cycle aborts with no done
    do_op(4'd13, 4'd3, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_Q", Q, 0);
    check("abort_R", R, 0);
    check("abort_ERR", ERR, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    do_op(4'd11, 4'd3, 1);
    wait_drain();
    check("post_abort_Q", Q, 3);

    // Exhaustive sweep with start held high
    first = 1'b1;
    last_idle = 0;
    prev_b = '0;
    start = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp_t e;
        n = 0;
        while (busy && n < 20) begin
          @(negedge clk);
          n++;
        end
        if (n >= 20) check("sweep_idle_timeout", 0, 1);
        if (!first && prev_b != 0) check("sweep_period", cyc - last_idle, 6);
        first = 1'b0;
        last_idle = cyc;
        prev_b = 4'(b);
        A = 4'(a);
        B = 4'(b);
        e.q   = (b == 0) ? 4'd0 : 4'(a / b);
        e.r   = (b == 0) ? 4'd0 : 4'(a % b);
        e.err = (b == 0);
        e.c   = cyc + ((b == 0) ? 1 : 5);
        sb.push_back(e);
        @(negedge clk);
      end
    end
    start = 1'b0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
